// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a two-entry skid buffer: ready is fully registered, throughput is
// one instruction per cycle, and a flush kills every held instruction.
module if_id_stage #(
  parameter int unsigned            ADDR_W   = 16,
  parameter int unsigned            INST_W   = 16,
  parameter logic [INST_W-1:0]      NOP_INST = '0,
  parameter int unsigned            CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] instAddr_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic              main_valid_q, main_valid_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_xfer, out_xfer;

  // Ready depends only on skid occupancy, so out_ready_i never reaches in_ready_o.
  assign in_xfer  = in_valid_i & ~skid_valid_q;
  assign out_xfer = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_addr_d  = main_addr_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_inst_d  = skid_inst_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_addr_d  = skid_addr_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_addr_d = instAddr_i;
          skid_inst_d = inst_i;
        end
      end else begin
        main_valid_d = in_xfer;
        // Address is kept on invalidation so instAddr_o shows the last instruction.
        if (in_xfer) begin
          main_addr_d = instAddr_i;
          main_inst_d = inst_i;
        end
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_addr_d  = instAddr_i;
      skid_inst_d  = inst_i;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready_i && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_addr_q  <= '0;
      main_inst_q  <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_inst_q  <= NOP_INST;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_addr_q  <= main_addr_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_inst_q  <= skid_inst_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign instAddr_o  = main_addr_q;
  assign inst_o      = main_valid_q ? main_inst_q : NOP_INST;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: default, 4-bit counter and 32-bit/NOP variants share stimulus.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, in_valid_i, out_ready_i;
  logic [15:0] addr_i, inst_i;

  logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
  logic [15:0] addr_a, inst_a, stall_a, addr_b, inst_b;
  logic [3:0]  stall_b;
  logic [31:0] addr_c, inst_c;
  logic [15:0] stall_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_stage u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy_a),
    .instAddr_i(addr_i), .inst_i(inst_i), .out_valid_o(vld_a), .out_ready_i(out_ready_i),
    .instAddr_o(addr_a), .inst_o(inst_a), .stall_cnt_o(stall_a)
  );

  if_id_stage #(.CNT_W(4)) u_dut_cnt4 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy_b),
    .instAddr_i(addr_i), .inst_i(inst_i), .out_valid_o(vld_b), .out_ready_i(out_ready_i),
    .instAddr_o(addr_b), .inst_o(inst_b), .stall_cnt_o(stall_b)
  );

  if_id_stage #(.ADDR_W(32), .INST_W(32), .NOP_INST(32'h0000_0013)) u_dut_w32 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy_c),
    .instAddr_i({16'h0, addr_i}), .inst_i({16'h0, inst_i}), .out_valid_o(vld_c),
    .out_ready_i(out_ready_i), .instAddr_o(addr_c), .inst_o(inst_c), .stall_cnt_o(stall_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d);
    in_valid_i = v;
    addr_i     = a;
    inst_i     = d;
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    #12;
    check("rst_valid", vld_a, 0);
    check("rst_inst", inst_a, 16'h0);
    check("rst_addr", addr_a, 16'h0);
    check("rst_ready", rdy_a, 1);
    check("rst_stall", stall_a, 0);
    check("rst_inst32", inst_c, 32'h13);
    rst = 1'b1;
    step();

    // Streaming at one per cycle.
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(i), 16'hA000 + 16'(i));
      step();
      check("strm_valid", vld_a, 1);
      check("strm_addr", addr_a, i);
      check("strm_inst", inst_a, 16'hA000 + i);
      check("strm_ready", rdy_a, 1);
      check("strm_addr32", addr_c, i);
      check("strm_inst32", inst_c, 32'hA000 + i);
    end
    drive(1'b0, 16'h0, 16'h0);
    step();
    check("strm_idle_valid", vld_a, 0);
    check("strm_idle_nop", inst_a, 16'h0);
    check("strm_idle_addr", addr_a, 16'h9);
    check("strm_idle_nop32", inst_c, 32'h13);
    check("strm_stall", stall_a, 0);

    // Backpressure: A in main, B in skid, C held off.
    out_ready_i = 1'b0;
    drive(1'b1, 16'h0010, 16'h1234);
    step();
    check("bp_a_inst", inst_a, 16'h1234);
    check("bp_a_ready", rdy_a, 1);
    drive(1'b1, 16'h0011, 16'h5678);
    step();
    check("bp_b_ready", rdy_a, 0);
    check("bp_b_main", inst_a, 16'h1234);
    check("bp_b_stall", stall_a, 1);
    drive(1'b1, 16'h0012, 16'h9ABC);
    step();
    check("bp_c_ready", rdy_a, 0);
    check("bp_c_addr", addr_a, 16'h0010);
    check("bp_c_stall", stall_a, 2);
    out_ready_i = 1'b1;
    step();
    check("bp_out_b", inst_a, 16'h5678);
    check("bp_out_b_ready", rdy_a, 1);
    step();
    check("bp_out_c", inst_a, 16'h9ABC);
    check("bp_out_c_addr", addr_a, 16'h0012);
    drive(1'b0, 16'h0, 16'h0);
    step();
    check("bp_drain", vld_a, 0);
    check("bp_stall_final", stall_a, 2);

    // Flush with both entries full and a same-cycle input.
    out_ready_i = 1'b0;
    drive(1'b1, 16'h0020, 16'h1111);
    step();
    drive(1'b1, 16'h0021, 16'h2222);
    step();
    check("fl_full_ready", rdy_a, 0);
    flush_i = 1'b1;
    drive(1'b1, 16'h0022, 16'h3333);
    step();
    check("fl_valid", vld_a, 0);
    check("fl_nop", inst_a, 16'h0);
    check("fl_ready", rdy_a, 1);
    check("fl_addr_hold", addr_a, 16'h0020);
    check("fl_stall", stall_a, 4);
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    step();
    check("fl_no_ghost", vld_a, 0);
    step();
    check("fl_no_ghost2", vld_a, 0);

    // Stall counter saturation on the 4-bit instance.
    out_ready_i = 1'b0;
    drive(1'b1, 16'h0030, 16'h4444);
    step();
    drive(1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", stall_b, 4'hF);
    check("sat_cnt16", stall_a, 24);
    check("sat_valid", vld_b, 1);

    // Asynchronous reset between edges with both entries full.
    drive(1'b1, 16'h0040, 16'h5555);
    step();
    check("ar_full", rdy_a, 0);
    drive(1'b0, 16'h0, 16'h0);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", vld_a, 0);
    check("ar_inst", inst_a, 16'h0);
    check("ar_addr", addr_a, 16'h0);
    check("ar_ready", rdy_a, 1);
    check("ar_stall", stall_a, 0);
    check("ar_stall4", stall_b, 0);
    check("ar_inst32", inst_c, 32'h13);
    step();
    rst = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 16'h0050, 16'h6666);
    step();
    check("post_rst_valid", vld_a, 1);
    check("post_rst_inst", inst_a, 16'h6666);
    check("post_rst_addr", addr_a, 16'h0050);
    drive(1'b0, 16'h0, 16'h0);
    step();
    check("post_rst_drain", vld_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
